mdr_bcd_display: RTL and testbench

MDR_BCD_DISPLAY -- requirements
Module: mdr_bcd_display

---
 rtl/mdr_bcd_display.sv | 122 ++++++++++++
 tb/tb_mdr_bcd_display.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mdr_bcd_display.sv
// Converts a signed result word to sign + BCD magnitude with double-dabble,
// then registers per-digit seven-segment patterns with leading-zero blanking.
module mdr_bcd_display #(
  parameter int DW = 16,
  parameter int ND = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DW-1:0]     i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sign,
  output logic [4*ND-1:0]   o_bcd,
  output logic [7*ND-1:0]   o_seg
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt_p1;
  logic signed [DW-1:0]  cap_p0;
  logic                  sign_p1;
  logic [DW-1:0]         mag_p1;
  logic [4*ND-1:0]       acc_p1;

  function automatic logic [4*ND-1:0] dabble(input logic [4*ND-1:0] acc);
    logic [4*ND-1:0] r;
    r = acc;
    for (int i = 0; i < ND; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Digits above the highest non-zero digit are blanked; units always shown.
  function automatic logic [7*ND-1:0] seg_all(input logic [4*ND-1:0] bcd);
    logic [7*ND-1:0] r;
    logic            nz;
    r  = '1;
    nz = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      nz = nz | (bcd[4*i +: 4] != 4'd0);
      if (nz || i == 0) r[7*i +: 7] = seg7(bcd[4*i +: 4]);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt_p1 == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_p1 <= '0;
    else if (state == LOAD)  cnt_p1 <= CW'(DW);
    else if (state == SHIFT) cnt_p1 <= cnt_p1 - CW'(1);
  end

  // Stage p0: capture request; stage p1: sign/magnitude and the dabble loop
  always_ff @(posedge clk) begin
    if (state == IDLE && i_start) cap_p0 <= $signed(i_data);
    if (state == LOAD) begin
      sign_p1 <= cap_p0[DW-1];
      mag_p1  <= $unsigned(cap_p0[DW-1] ? -cap_p0 : cap_p0);
      acc_p1  <= '0;
    end else if (state == SHIFT) begin
      {acc_p1, mag_p1} <= {dabble(acc_p1), mag_p1} << 1;
    end
  end

  // Output registers: updated only on the DONE cycle, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sign <= 1'b0;
      o_bcd  <= '0;
      o_seg  <= '1;
    end else begin
      o_busy <= (state_nxt != IDLE);
      o_done <= (state == DONE);
      if (state == DONE) begin
        o_sign <= sign_p1;
        o_bcd  <= acc_p1;
        o_seg  <= seg_all(acc_p1);
      end
    end
  end

endmodule

// File: tb/tb_mdr_bcd_display.sv
// Directed bench for mdr_bcd_display: latency, BCD/segment results,
// busy/start handling and asynchronous reset abort.
module tb_mdr_bcd_display;

  localparam int DW = 16;
  localparam int ND = 5;

  localparam logic [6:0] BL = 7'h7f;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [DW-1:0]     i_data;
  logic              o_busy, o_done, o_sign;
  logic [4*ND-1:0]   o_bcd;
  logic [7*ND-1:0]   o_seg;

  int n_cmp = 0;
  int n_bad = 0;

  mdr_bcd_display #(.DW(DW), .ND(ND)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .o_busy(o_busy), .o_done(o_done), .o_sign(o_sign),
    .o_bcd(o_bcd), .o_seg(o_seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion, verify hold of previous outputs mid-run, then the result.
  task automatic run(input string tag, input logic [DW-1:0] d,
                     input logic [19:0] prev_bcd, input logic [19:0] exp_bcd,
                     input logic exp_sign, input logic [34:0] exp_seg);
    int n;
    i_data  = d;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_done0"}, o_done, 0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 9) begin
        i_data = 16'h1111;
        chk({tag, "_hold"}, o_bcd, prev_bcd);
      end
      if (o_done) break;
    end
    chk({tag, "_lat"}, n, 18);
    chk({tag, "_bcd"}, o_bcd, exp_bcd);
    chk({tag, "_sign"}, o_sign, exp_sign);
    chk({tag, "_seg"}, o_seg, exp_seg);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    rst     = 1'b1;
    i_start = 1'b0;
    i_data  = '0;
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sign", o_sign, 0);
    chk("rst_bcd",  o_bcd, 0);
    chk("rst_seg",  o_seg, {BL, BL, BL, BL, BL});
    tick();
    tick();
    rst = 1'b0;
    tick();

    run("p1234", 16'd1234, 20'h0, 20'h01234, 1'b0, {BL, S1, S2, S3, S4});
    tick();
    chk("p1234_pulse", o_done, 0);

    run("m1", 16'hFFFF, 20'h01234, 20'h00001, 1'b1, {BL, BL, BL, BL, S1});
    run("m32768", 16'h8000, 20'h00001, 20'h32768, 1'b1, {S3, S2, S7, S6, S8});
    run("p32767", 16'h7FFF, 20'h32768, 20'h32767, 1'b0, {S3, S2, S7, S6, S7});
    tick();
    chk("p32767_pulse", o_done, 0);
    run("zero", 16'd0, 20'h32767, 20'h00000, 1'b0, {BL, BL, BL, BL, S0});

    // Starts during busy (cycles 3, 10) and in DONE (cycle 18) are ignored
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0)                       begin i_start = 1'b1; i_data = 16'd5; end
      else if (k == 3 || k == 10 || k == 18) begin i_start = 1'b1; i_data = 16'd9; end
      else                              i_start = 1'b0;
      tick();
      if (o_busy && busy_cnt == k) busy_cnt++;
      if (o_done) done_cnt++;
    end
    i_start = 1'b0;
    chk("ign_busy", busy_cnt, 18);
    chk("ign_done", done_cnt, 1);
    chk("ign_bcd",  o_bcd, 20'h00005);
    chk("ign_seg",  o_seg, {BL, BL, BL, BL, S5});
    chk("ign_idle", o_busy, 0);

    // Reset during SHIFT of 999
    i_data  = 16'd999;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    #2;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_sign", o_sign, 0);
    chk("abort_bcd",  o_bcd, 0);
    chk("abort_seg",  o_seg, {BL, BL, BL, BL, BL});
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_done) done_cnt++;
    end
    chk("abort_nodone", done_cnt, 0);
    chk("abort_keep", o_bcd, 0);

    run("p42", 16'd42, 20'h0, 20'h00042, 1'b0, {BL, BL, BL, S4, S2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
